// File: rtl/npc_micro_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_micro_pkg
// Description : Shared micro-command definitions for the decoder and the
//               load/store unit: memory access size encoding, LSU state
//               encoding and datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_micro_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Same encoding as the decoder's Mren/Mwen micro-command fields.
    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_BYTE = 2'b01,
        MEM_HALF = 2'b10,
        MEM_WORD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_REQ      = 2'd1,
        LSU_WAIT_RSP = 2'd2,
        LSU_DONE     = 2'd3
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane alignment for a 32-bit data port.
//               Store side: builds the byte strobe and replicates store data
//               across lanes. Load side: extracts the addressed byte/half and
//               sign- or zero-extends it.
// Ports       : i_st_size/i_st_off/i_st_wdata -> o_st_wmask/o_st_wdata
//               i_ld_size/i_ld_off/i_ld_unsigned/i_ld_rdata -> o_ld_data
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import npc_micro_pkg::*;
(
    input  mem_size_t   i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_wmask,
    output logic [31:0] o_st_wdata,

    input  mem_size_t   i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shifted;

    always_comb begin
        o_st_wmask = 4'b0000;
        o_st_wdata = i_st_wdata;
        case (i_st_size)
            MEM_BYTE: begin
                o_st_wmask = 4'b0001 << i_st_off;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            MEM_HALF: begin
                // At offset 3 the upper strobe bit falls off the word.
                o_st_wmask = 4'b0011 << i_st_off;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            MEM_WORD: begin
                o_st_wmask = 4'b1111;
            end
            default: begin
                o_st_wmask = 4'b0000;
            end
        endcase
    end

    // Zero-filling right shift: a half read at offset 3 sees zero above
    // rdata[31:24].
    assign w_ld_shifted = i_ld_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_size)
            MEM_BYTE: o_ld_data = {{24{w_ld_shifted[7]  & ~i_ld_unsigned}}, w_ld_shifted[7:0]};
            MEM_HALF: o_ld_data = {{16{w_ld_shifted[15] & ~i_ld_unsigned}}, w_ld_shifted[15:0]};
            default:  o_ld_data = i_ld_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Multi-cycle load/store controller. Accepts one memory
//               micro-op from execute (req_*), drives a valid/ready data
//               memory port (mem_*), and returns extended load data with a
//               one-cycle done pulse (done/wb_valid/wb_data/err).
//               req_ready is high only in IDLE so the core stalls while an
//               access is outstanding.
// Config      : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//               accesses complete with err=1 without touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int ADDR_W = npc_micro_pkg::ADDR_W,
    parameter int DATA_W = npc_micro_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mren,
    input  logic [1:0]        req_mwen,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              done,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    import npc_micro_pkg::*;

    lsu_state_t  r_state;
    mem_size_t   r_size;
    logic [1:0]  r_off;
    logic        r_unsigned;
    logic        r_is_store;
    logic        r_req_ready;
    logic        r_mem_valid;
    logic        r_mem_wen;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]  r_mem_wmask;
    logic [DATA_W-1:0] r_mem_wdata;
    logic        r_done;
    logic        r_wb_valid;
    logic [DATA_W-1:0] r_wb_data;
    logic        r_err;

    logic        w_has_rd;
    logic        w_has_wr;
    mem_size_t   w_req_size;
    logic [3:0]  w_st_wmask;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;

    assign w_has_rd   = (req_mren != 2'b00);
    assign w_has_wr   = (req_mwen != 2'b00);
    assign w_req_size = w_has_wr ? mem_size_t'(req_mwen) : mem_size_t'(req_mren);

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((w_req_size == MEM_HALF) && req_addr[0]) ||
                        ((w_req_size == MEM_WORD) && (req_addr[1:0] != 2'b00));
`endif

    // Store side is fed straight from the request so the lane-shifted data
    // can be registered at accept; load side uses the captured size/offset.
    lsu_lane_align u_lane_align (
        .i_st_size     (w_req_size),
        .i_st_off      (req_addr[1:0]),
        .i_st_wdata    (req_wdata),
        .o_st_wmask    (w_st_wmask),
        .o_st_wdata    (w_st_wdata),
        .i_ld_size     (r_size),
        .i_ld_off      (r_off),
        .i_ld_unsigned (r_unsigned),
        .i_ld_rdata    (mem_rdata),
        .o_ld_data     (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LSU_IDLE;
            r_size      <= MEM_NONE;
            r_off       <= 2'b00;
            r_unsigned  <= 1'b0;
            r_is_store  <= 1'b0;
            r_req_ready <= 1'b1;
            r_mem_valid <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wmask <= 4'b0000;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_data   <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        r_size      <= w_req_size;
                        r_off       <= req_addr[1:0];
                        r_unsigned  <= req_unsigned;
                        r_is_store  <= w_has_wr;
                        r_req_ready <= 1'b0;
                        if (!w_has_rd && !w_has_wr) begin
                            r_state <= LSU_DONE;
                            r_done  <= 1'b1;
                        end else if (w_has_rd && w_has_wr) begin
                            r_state <= LSU_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                        end else if (w_misalign) begin
                            r_state <= LSU_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
`endif
                        end else begin
                            r_state     <= LSU_REQ;
                            r_mem_valid <= 1'b1;
                            r_mem_wen   <= w_has_wr;
                            r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            r_mem_wmask <= w_has_wr ? w_st_wmask : 4'b0000;
                            r_mem_wdata <= w_st_wdata;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (r_is_store) begin
                            r_state <= LSU_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= LSU_WAIT_RSP;
                        end
                    end
                end
                LSU_WAIT_RSP: begin
                    if (mem_rvalid) begin
                        r_state    <= LSU_DONE;
                        r_done     <= 1'b1;
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= w_ld_data;
                    end
                end
                LSU_DONE: begin
                    // wb_data deliberately held until the next load completes.
                    r_state     <= LSU_IDLE;
                    r_done      <= 1'b0;
                    r_wb_valid  <= 1'b0;
                    r_err       <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= LSU_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign mem_valid = r_mem_valid;
    assign mem_wen   = r_mem_wen;
    assign mem_addr  = r_mem_addr;
    assign mem_wmask = r_mem_wmask;
    assign mem_wdata = r_mem_wdata;
    assign done      = r_done;
    assign wb_valid  = r_wb_valid;
    assign wb_data   = r_wb_data;
    assign err       = r_err;

endmodule
`default_nettype wire
